// File: rtl/ahb_dmem_responder_if.sv
// AHB-lite slave-side bus bundle for the data memory responder.
// Signal names keep the slave-port view of the bus.
interface ahb_dmem_responder_if;
  logic        s_hsel_i;
  logic [31:0] s_haddr_i;
  logic [1:0]  s_htrans_i;
  logic        s_hwrite_i;
  logic [2:0]  s_hsize_i;
  logic [31:0] s_hwdata_i;
  logic        s_hready_i;
  logic [31:0] s_hrdata_o;
  logic        s_hready_o;
  logic        s_hresp_o;

  modport master (
    output s_hsel_i, s_haddr_i, s_htrans_i, s_hwrite_i,
    output s_hsize_i, s_hwdata_i, s_hready_i,
    input  s_hrdata_o, s_hready_o, s_hresp_o
  );

  modport slave (
    input  s_hsel_i, s_haddr_i, s_htrans_i, s_hwrite_i,
    input  s_hsize_i, s_hwdata_i, s_hready_i,
    output s_hrdata_o, s_hready_o, s_hresp_o
  );
endinterface

// File: rtl/ahb_dmem_responder.sv
// AHB-lite data memory slave with configurable wait states
// and two-cycle ERROR responses for illegal transfers.
module ahb_dmem_responder #(
  parameter int MEM_SIZE    = 4096,
  parameter int WAIT_STATES = 0
) (
  input  logic                 s_clk_i,
  input  logic                 s_resetn_i,
  ahb_dmem_responder_if.slave  bus
);

  localparam int AW    = $clog2(MEM_SIZE);
  localparam int IW    = (AW > 2) ? AW - 2 : 1;
  localparam int DEPTH = MEM_SIZE / 4;
  localparam bit HAS_WAIT = (WAIT_STATES > 0);
  localparam logic [3:0] WS_LOAD =
    HAS_WAIT ? 4'(WAIT_STATES - 1) : 4'd0;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_ERR1 = 2'd2;
  localparam logic [1:0] S_ERR2 = 2'd3;

  logic [1:0]    state;
  logic [3:0]    cnt;
  logic          dp_valid;
  logic          dp_write;
  logic [IW-1:0] dp_idx;
  logic [3:0]    dp_be;

  logic [31:0] mem [DEPTH];

  logic          open_slot;
  logic          accept;
  logic          bad;
  logic          commit;
  logic [3:0]    be;
  logic [IW-1:0] idx;

  assign open_slot = (state == S_IDLE) || (state == S_ERR2);
  assign accept = open_slot && bus.s_hsel_i &&
                  bus.s_htrans_i[1] && bus.s_hready_i;

  assign bad =
    (bus.s_haddr_i >= 32'(MEM_SIZE)) ||
    (bus.s_hsize_i > 3'd2) ||
    ((bus.s_hsize_i == 3'd1) && bus.s_haddr_i[0]) ||
    ((bus.s_hsize_i == 3'd2) && (bus.s_haddr_i[1:0] != 2'b00));

  assign idx = IW'(bus.s_haddr_i >> 2);

  // little-endian lane enables; only meaningful for legal sizes
  always_comb begin
    be = 4'b0000;
    unique case (1'b1)
      bus.s_hsize_i == 3'd0:
        be = 4'b0001 << bus.s_haddr_i[1:0];
      bus.s_hsize_i == 3'd1:
        be = 4'b0011 << {bus.s_haddr_i[1], 1'b0};
      bus.s_hsize_i == 3'd2:
        be = 4'b1111;
      default:
        be = 4'b0000;
    endcase
  end

  always_ff @(posedge s_clk_i or negedge s_resetn_i) begin
    if (!s_resetn_i) begin
      state    <= S_IDLE;
      cnt      <= 4'd0;
      dp_valid <= 1'b0;
      dp_write <= 1'b0;
      dp_idx   <= '0;
      dp_be    <= 4'b0000;
    end else begin
      unique case (state)
        S_WAIT: begin
          if (cnt == 4'd0) state <= S_IDLE;
          else cnt <= cnt - 4'd1;
        end
        S_ERR1: state <= S_ERR2;
        S_IDLE, S_ERR2: begin
          dp_valid <= accept && !bad;
          if (accept) begin
            dp_write <= bus.s_hwrite_i;
            dp_idx   <= idx;
            dp_be    <= be;
          end
          if (accept && bad) begin
            state <= S_ERR1;
          end else if (accept && HAS_WAIT) begin
            state <= S_WAIT;
            cnt   <= WS_LOAD;
          end else begin
            state <= S_IDLE;
          end
        end
      endcase
    end
  end

  // completion cycle of a valid transfer is IDLE with a pending phase
  assign commit = (state == S_IDLE) && dp_valid && dp_write;

  always_ff @(posedge s_clk_i) begin
    if (commit) begin
      for (int b = 0; b < 4; b++) begin
        if (dp_be[b]) mem[dp_idx][8*b +: 8] <= bus.s_hwdata_i[8*b +: 8];
      end
    end
  end

  assign bus.s_hrdata_o =
    ((state == S_IDLE) && dp_valid && !dp_write) ? mem[dp_idx] : 32'h0;
  assign bus.s_hready_o = !((state == S_WAIT) || (state == S_ERR1));
  assign bus.s_hresp_o  = (state == S_ERR1) || (state == S_ERR2);

endmodule

// File: tb/tb_ahb_dmem_responder.sv
// Bench for ahb_dmem_responder: two instances (0 and 3 wait states)
// checked every cycle against a transaction-level memory model.
module tb_ahb_dmem_responder;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]  sel;
  logic [31:0] haddr;
  logic [31:0] hwdata;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize;
  logic        force_low;

  ahb_dmem_responder_if if0 ();
  ahb_dmem_responder_if if1 ();

  assign if0.s_hsel_i   = sel[0];
  assign if0.s_haddr_i  = haddr;
  assign if0.s_htrans_i = htrans;
  assign if0.s_hwrite_i = hwrite;
  assign if0.s_hsize_i  = hsize;
  assign if0.s_hwdata_i = hwdata;
  assign if0.s_hready_i = if0.s_hready_o & ~force_low;

  assign if1.s_hsel_i   = sel[1];
  assign if1.s_haddr_i  = haddr;
  assign if1.s_htrans_i = htrans;
  assign if1.s_hwrite_i = hwrite;
  assign if1.s_hsize_i  = hsize;
  assign if1.s_hwdata_i = hwdata;
  assign if1.s_hready_i = if1.s_hready_o & ~force_low;

  ahb_dmem_responder #(.MEM_SIZE(4096), .WAIT_STATES(0)) u0 (
    .s_clk_i(clk), .s_resetn_i(rst_n), .bus(if0));
  ahb_dmem_responder #(.MEM_SIZE(256), .WAIT_STATES(3)) u1 (
    .s_clk_i(clk), .s_resetn_i(rst_n), .bus(if1));

  logic        rdy_o  [2];
  logic        resp_o [2];
  logic [31:0] rd_o   [2];
  assign rdy_o[0]  = if0.s_hready_o;
  assign rdy_o[1]  = if1.s_hready_o;
  assign resp_o[0] = if0.s_hresp_o;
  assign resp_o[1] = if1.s_hresp_o;
  assign rd_o[0]   = if0.s_hrdata_o;
  assign rd_o[1]   = if1.s_hrdata_o;

  function automatic int msz(input int d);
    return (d == 1) ? 256 : 4096;
  endfunction
  function automatic int wsn(input int d);
    return (d == 1) ? 3 : 0;
  endfunction

  int nchk = 0;
  int nerr = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // transaction-level model: error cycles left, wait cycles left, byte memory
  int          busy_left [2];
  int          err_left  [2];
  bit          pend      [2];
  logic [31:0] p_addr    [2];
  bit          p_wr      [2];
  logic [2:0]  p_size    [2];
  logic [7:0]  mm        [2][4096];

  function automatic logic [31:0] mword(input int d, input logic [31:0] a);
    int w;
    w = int'(a) & ~3;
    return {mm[d][w+3], mm[d][w+2], mm[d][w+1], mm[d][w]};
  endfunction

  task automatic model_step(input int d);
    logic er, ep;
    logic [31:0] ed;
    bit acc, bad;
    int b;
    if (!rst_n) begin
      busy_left[d] = 0;
      err_left[d]  = 0;
      pend[d]      = 1'b0;
      er = 1'b1; ep = 1'b0; ed = 32'h0;
    end else if (err_left[d] == 2) begin
      er = 1'b0; ep = 1'b1; ed = 32'h0;
    end else if (err_left[d] == 1) begin
      er = 1'b1; ep = 1'b1; ed = 32'h0;
    end else if (pend[d] && busy_left[d] > 0) begin
      er = 1'b0; ep = 1'b0; ed = 32'h0;
    end else if (pend[d] && !p_wr[d]) begin
      er = 1'b1; ep = 1'b0; ed = mword(d, p_addr[d]);
    end else begin
      er = 1'b1; ep = 1'b0; ed = 32'h0;
    end
    chk($sformatf("dut%0d hready_o", d), 32'(rdy_o[d]), 32'(er));
    chk($sformatf("dut%0d hresp_o", d), 32'(resp_o[d]), 32'(ep));
    chk($sformatf("dut%0d hrdata_o", d), rd_o[d], ed);
    if (rst_n) begin
      acc = er && !force_low && sel[d] && htrans[1];
      if (pend[d] && busy_left[d] > 0) begin
        busy_left[d]--;
      end else begin
        if (pend[d] && p_wr[d]) begin
          for (int k = 0; k < (1 << p_size[d]); k++) begin
            b = int'(p_addr[d]) + k;
            mm[d][b] = hwdata[8*(b%4) +: 8];
          end
        end
        pend[d] = 1'b0;
        if (err_left[d] > 0) err_left[d]--;
      end
      if (acc) begin
        bad = (haddr >= 32'(msz(d))) || (hsize > 3'd2) ||
              (hsize == 3'd1 && haddr % 2 != 0) ||
              (hsize == 3'd2 && haddr % 4 != 0);
        if (bad) begin
          err_left[d] = 2;
        end else begin
          pend[d]      = 1'b1;
          busy_left[d] = wsn(d);
          p_addr[d]    = haddr;
          p_wr[d]      = hwrite;
          p_size[d]    = hsize;
        end
      end
    end
  endtask

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) model_step(d);
  end

  logic [31:0] tx_addr  [8];
  logic [31:0] tx_data  [8];
  logic [31:0] tx_rdata [8];
  bit          tx_wr    [8];
  logic [2:0]  tx_size  [8];
  logic        tx_resp  [8];
  int          tx_low   [8];

  task automatic tx(input int k, input bit wr, input logic [31:0] a,
                    input logic [2:0] s, input logic [31:0] dat);
    tx_wr[k] = wr; tx_addr[k] = a; tx_size[k] = s; tx_data[k] = dat;
  endtask

  task automatic idle();
    sel = 2'b00; htrans = 2'b00; hwrite = 1'b0;
    haddr = 32'h0; hsize = 3'd0;
  endtask

  // pipelined master: address phase of i overlaps data phase of j
  task automatic run(input int d, input int n);
    int i, j, guard;
    logic rdy;
    i = 0; j = -1; guard = 0;
    for (int k = 0; k < n; k++) begin
      tx_low[k] = 0; tx_rdata[k] = 32'hx; tx_resp[k] = 1'bx;
    end
    while ((i < n || j >= 0) && guard < 200) begin
      guard++;
      if (i < n) begin
        sel = (d == 1) ? 2'b10 : 2'b01;
        htrans = 2'b10; haddr = tx_addr[i];
        hwrite = tx_wr[i]; hsize = tx_size[i];
      end else begin
        idle();
      end
      hwdata = (j >= 0) ? tx_data[j] : 32'h0;
      @(negedge clk);
      rdy = rdy_o[d];
      if (j >= 0) begin
        if (rdy) begin
          tx_rdata[j] = rd_o[d];
          tx_resp[j]  = resp_o[d];
        end else begin
          tx_low[j]++;
        end
      end
      @(posedge clk); #1;
      if (rdy) begin
        j = (i < n) ? i : -1;
        if (i < n) i++;
      end
    end
    idle();
    hwdata = 32'h0;
    nchk++;
    if (guard >= 200) begin
      nerr++;
      $display("FAIL run timeout: got %0d cycles, required < 200", guard);
    end
  endtask

  initial begin
    idle();
    hwdata = 32'h0;
    force_low = 1'b0;
    @(posedge clk); #1;
    chk("reset hready0", 32'(rdy_o[0]), 32'h1);
    chk("reset hresp0", 32'(resp_o[0]), 32'h0);
    chk("reset hrdata0", rd_o[0], 32'h0);
    chk("reset hready1", 32'(rdy_o[1]), 32'h1);
    chk("reset hresp1", 32'(resp_o[1]), 32'h0);
    chk("reset hrdata1", rd_o[1], 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    tx(0, 1, 32'h10, 3'd2, 32'hDEADBEEF);
    tx(1, 0, 32'h10, 3'd2, 32'h0);
    run(0, 2);
    chk("w/r rdata", tx_rdata[1], 32'hDEADBEEF);
    chk("w/r low wr", 32'(tx_low[0]), 32'd0);
    chk("w/r low rd", 32'(tx_low[1]), 32'd0);
    chk("w/r resp", 32'(tx_resp[1]), 32'h0);

    tx(0, 1, 32'h20, 3'd2, 32'h11223344);
    tx(1, 1, 32'h21, 3'd0, 32'hDEADAAEF);
    tx(2, 0, 32'h20, 3'd2, 32'h0);
    run(0, 3);
    chk("byte rdata", tx_rdata[2], 32'h1122AA44);

    tx(0, 1, 32'h30, 3'd2, 32'h01020304);
    tx(1, 1, 32'h32, 3'd1, 32'h55667788);
    tx(2, 1, 32'h30, 3'd0, 32'hFFFFFF99);
    tx(3, 0, 32'h30, 3'd2, 32'h0);
    run(0, 4);
    chk("half rdata", tx_rdata[3], 32'h55660399);

    tx(0, 1, 32'h22, 3'd2, 32'hFFFFFFFF);
    tx(1, 0, 32'd4096, 3'd2, 32'h0);
    tx(2, 0, 32'h20, 3'd2, 32'h0);
    tx(3, 0, 32'h0, 3'd3, 32'h0);
    run(0, 4);
    chk("misalign resp", 32'(tx_resp[0]), 32'h1);
    chk("misalign low", 32'(tx_low[0]), 32'd1);
    chk("range resp", 32'(tx_resp[1]), 32'h1);
    chk("range low", 32'(tx_low[1]), 32'd1);
    chk("range rdata", tx_rdata[1], 32'h0);
    chk("unchanged rdata", tx_rdata[2], 32'h1122AA44);
    chk("unchanged resp", 32'(tx_resp[2]), 32'h0);
    chk("size3 resp", 32'(tx_resp[3]), 32'h1);

    tx(0, 1, 32'h8, 3'd2, 32'hA5A50F0F);
    tx(1, 0, 32'h8, 3'd2, 32'h0);
    tx(2, 0, 32'h100, 3'd2, 32'h0);
    tx(3, 1, 32'hFC, 3'd2, 32'h0BADF00D);
    tx(4, 0, 32'hFC, 3'd2, 32'h0);
    run(1, 5);
    chk("ws3 low wr", 32'(tx_low[0]), 32'd3);
    chk("ws3 low rd", 32'(tx_low[1]), 32'd3);
    chk("ws3 rdata", tx_rdata[1], 32'hA5A50F0F);
    chk("ws3 err low", 32'(tx_low[2]), 32'd1);
    chk("ws3 err resp", 32'(tx_resp[2]), 32'h1);
    chk("ws3 top rdata", tx_rdata[4], 32'h0BADF00D);

    force_low = 1'b1;
    sel = 2'b01; htrans = 2'b10; haddr = 32'h10;
    hwrite = 1'b1; hsize = 3'd2; hwdata = 32'h55555555;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("nordy hready", 32'(rdy_o[0]), 32'h1);
    chk("nordy hresp", 32'(resp_o[0]), 32'h0);
    idle();
    @(posedge clk); #1;
    force_low = 1'b0;
    hwdata = 32'h0;
    tx(0, 0, 32'h10, 3'd2, 32'h0);
    run(0, 1);
    chk("nordy rdata", tx_rdata[0], 32'hDEADBEEF);

    tx(0, 1, 32'h40, 3'd2, 32'hCAFEF00D);
    run(1, 1);
    sel = 2'b10; htrans = 2'b10; haddr = 32'h40;
    hwrite = 1'b1; hsize = 3'd2;
    @(posedge clk); #1;
    idle();
    hwdata = 32'h12345678;
    @(posedge clk); #1;
    chk("pre-rst hready", 32'(rdy_o[1]), 32'h0);
    rst_n = 1'b0;
    #1;
    chk("rst hready", 32'(rdy_o[1]), 32'h1);
    chk("rst hresp", 32'(resp_o[1]), 32'h0);
    chk("rst hrdata", rd_o[1], 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    hwdata = 32'h0;
    @(posedge clk); #1;
    tx(0, 0, 32'h40, 3'd2, 32'h0);
    run(1, 1);
    chk("rst old rdata", tx_rdata[0], 32'hCAFEF00D);
    chk("rst rd low", 32'(tx_low[0]), 32'd3);

    @(posedge clk); #1;
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule

// File: doc/ahb_dmem_responder.md
AHB_DMEM_RESPONDER -- requirements
Module: ahb_dmem_responder

Interface
REQ-001 Parameter MEM_SIZE, default 4096, memory size in bytes; a power of two, at least 4.
REQ-002 Parameter WAIT_STATES, default 0, wait cycles inserted per OKAY transfer; legal range 0..15.
REQ-003 s_clk_i  in  1  clock; all state updates on the rising edge.
REQ-004 s_resetn_i  in  1  reset; asynchronous, active-low.
REQ-005 s_hsel_i  in  1  slave select.
REQ-006 s_haddr_i  in  32  byte address, address phase.
REQ-007 s_htrans_i  in  2  IDLE=00, BUSY=01, NONSEQ=10, SEQ=11.
REQ-008 s_hwrite_i  in  1  1 = write.
REQ-009 s_hsize_i  in  3  0 = byte, 1 = halfword, 2 = word.
REQ-010 s_hwdata_i  in  32  write data, data phase.
REQ-011 s_hready_i  in  1  bus HREADY (HREADYIN).
REQ-012 s_hrdata_o  out  32  read data.
REQ-013 s_hready_o  out  1  transfer-done indicator (HREADYOUT).
REQ-014 s_hresp_o  out  1  0 = OKAY, 1 = ERROR.

Function
REQ-015 Transfer accepted at an edge when s_hsel_i=1, s_htrans_i[1]=1 and s_hready_i=1; the block SHALL register haddr, hwrite and hsize at that edge.
REQ-016 When s_hready_i=0, the block SHALL ignore all address-phase inputs.
REQ-017 IDLE or BUSY transfers, and unselected cycles, SHALL get a zero-wait OKAY response: hready_o=1, hresp_o=0.
REQ-018 An accepted transfer SHALL be an error transfer if any of these holds:
- haddr >= MEM_SIZE;
- hsize > 2;
- halfword with haddr[0]=1;
- word with haddr[1:0]!=0.
REQ-019 FSM states: IDLE, WAIT, ERR1, ERR2. The reset state SHALL be IDLE.
REQ-020 IDLE: hready_o=1, hresp_o=0.
- Valid accept with WAIT_STATES>0 -> WAIT, with the counter loaded to WAIT_STATES-1.
- Valid accept with WAIT_STATES=0 -> stay in IDLE; the data phase completes in the next cycle.
- Error accept -> ERR1.
REQ-021 WAIT: hready_o=0, hresp_o=0; the counter SHALL decrement each cycle; counter=0 -> data-phase completion cycle (hready_o=1).
REQ-022 ERR1: hready_o=0, hresp_o=1, then ERR2. ERR2: hready_o=1, hresp_o=1.
REQ-023 Every error response SHALL last exactly 2 cycles, independent of WAIT_STATES.
REQ-024 In ERR2, a new accepted transfer SHALL be processed as in IDLE.
REQ-025 The completion cycle of a valid transfer SHALL permit a pipelined accept of the next transfer (back-to-back, no idle gap).
REQ-026 Writes SHALL update memory at the edge ending the completion cycle, using s_hwdata_i from that cycle.
- Byte lanes are little-endian and selected by addr[1:0] and hsize.
- Unselected bytes are unchanged.
REQ-027 Read completion cycle: s_hrdata_o SHALL present the full aligned word at addr[31:2] combinationally from the array. It SHALL equal 0 in all other cycles.
REQ-028 A read accepted in the completion cycle of a write to the same word SHALL return the newly written data.
REQ-029 Error transfers SHALL NOT modify memory, and s_hrdata_o SHALL be 0 during them.
REQ-030 The wait counter SHALL be 4 bits wide, never underflow, and not be re-loaded while in WAIT.

Reset
REQ-031 Reset assertion SHALL immediately force IDLE, counter=0, hready_o=1, hresp_o=0, hrdata_o=0, and discard any pending data phase.
REQ-032 A write whose data phase is interrupted by reset SHALL NOT modify memory. Memory contents are not reset.
REQ-033 After reset release, the first edge with a valid accept SHALL start a normal transfer.

Verification
REQ-034 Word write then read, WAIT_STATES=0.
- Stimulus: write 0xDEADBEEF to 0x10, then a read of 0x10 accepted in the write completion cycle.
- Response: hrdata=0xDEADBEEF, hready_o never low.
REQ-035 Byte write.
- Stimulus: word 0x11223344 at 0x20, then a byte write of 0xAA (lane 1) to 0x21.
- Response: a word read returns 0x1122AA44.
REQ-036 Wait states, WAIT_STATES=3.
- Stimulus: a read.
- Response: hready_o low for exactly 3 cycles, then high with valid hrdata.
REQ-037 Misaligned or out-of-range access.
- Stimulus: a word write to 0x22, then a read of MEM_SIZE.
- Response: each gets ERR1 (hready_o=0, hresp_o=1) then ERR2 (1,1); memory is unchanged.
REQ-038 Reset and hready_i handling.
- Stimulus: s_resetn_i=0 during WAIT of a write.
- Response: outputs return to reset values at once, and a later read shows the old data.
- Stimulus: NONSEQ with s_hready_i=0.
- Response: not accepted.
